// File: rtl/decode.sv
// MIPS decode stage: register file with M/W forwarding, branch/jump
// resolution driving NPC, immediate extension and the D/E pipeline register.
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_PC,
    input  logic [31:0] D_Ins,
    input  logic [31:0] F_PC,
    input  logic        E_Flush,
    input  logic [4:0]  M_A3,
    input  logic [31:0] M_WD,
    input  logic        W_WE,
    input  logic [4:0]  W_A3,
    input  logic [31:0] W_WD,
    output logic [31:0] NPC,
    output logic [4:0]  D_rs,
    output logic [4:0]  D_rt,
    output logic [31:0] E_PC,
    output logic [31:0] E_Ins,
    output logic [31:0] E_RS,
    output logic [31:0] E_RT,
    output logic [31:0] E_EXT,
    output logic [4:0]  E_A3
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NREG = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    logic [DW-1:0] r_grf [NREG];

    logic [DW-1:0] r_e_pc, r_e_ins, r_e_rs, r_e_rt, r_e_ext;
    logic [AW-1:0] r_e_a3;

    logic [5:0]    w_op, w_funct;
    logic [AW-1:0] w_rs_a, w_rt_a, w_rd_a;
    logic [15:0]   w_imm;
    logic [25:0]   w_index;
    logic          w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic [DW-1:0] w_rs_v, w_rt_v, w_sext, w_ext, w_npc;
    logic [AW-1:0] w_a3;

    // Field extraction and opcode decode; anything unlisted falls out as a nop.
    always_comb begin
        w_op    = D_Ins[31:26];
        w_rs_a  = D_Ins[25:21];
        w_rt_a  = D_Ins[20:16];
        w_rd_a  = D_Ins[15:11];
        w_funct = D_Ins[5:0];
        w_imm   = D_Ins[15:0];
        w_index = D_Ins[25:0];

        w_addu = (w_op == OP_RTYPE) && (w_funct == FN_ADDU);
        w_subu = (w_op == OP_RTYPE) && (w_funct == FN_SUBU);
        w_jr   = (w_op == OP_RTYPE) && (w_funct == FN_JR);
        w_ori  = (w_op == OP_ORI);
        w_lui  = (w_op == OP_LUI);
        w_lw   = (w_op == OP_LW);
        w_sw   = (w_op == OP_SW);
        w_beq  = (w_op == OP_BEQ);
        w_j    = (w_op == OP_J);
        w_jal  = (w_op == OP_JAL);
    end

    // Operand select: $0, then M forward, then same-cycle W bypass, then GRF.
    always_comb begin
        w_rs_v = '0;
        w_rt_v = '0;
        if (w_rs_a == '0)
            w_rs_v = '0;
        else if (M_A3 == w_rs_a)
            w_rs_v = M_WD;
        else if (W_WE && (W_A3 == w_rs_a))
            w_rs_v = W_WD;
        else
            w_rs_v = r_grf[w_rs_a];

        if (w_rt_a == '0)
            w_rt_v = '0;
        else if (M_A3 == w_rt_a)
            w_rt_v = M_WD;
        else if (W_WE && (W_A3 == w_rt_a))
            w_rt_v = W_WD;
        else
            w_rt_v = r_grf[w_rt_a];
    end

    // Immediate extension, destination register and next-PC selection.
    always_comb begin
        w_sext = {{16{w_imm[15]}}, w_imm};

        w_ext = '0;
        if (w_ori)
            w_ext = {16'h0000, w_imm};
        else if (w_lw || w_sw || w_beq)
            w_ext = w_sext;
        else if (w_lui)
            w_ext = {w_imm, 16'h0000};

        w_a3 = '0;
        if (w_addu || w_subu)
            w_a3 = w_rd_a;
        else if (w_ori || w_lw || w_lui)
            w_a3 = w_rt_a;
        else if (w_jal)
            w_a3 = AW'(31);

        w_npc = F_PC + DW'(4);
        if (w_beq && (w_rs_v == w_rt_v))
            w_npc = D_PC + DW'(4) + {w_sext[29:0], 2'b00};
        else if (w_j || w_jal)
            w_npc = {D_PC[31:28], w_index, 2'b00};
        else if (w_jr)
            w_npc = w_rs_v;
    end

    // Register file; $0 is never written so it always reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++)
                r_grf[i] <= '0;
        end else if (W_WE && (W_A3 != '0)) begin
            r_grf[W_A3] <= W_WD;
        end
    end

    // D/E pipeline register; flush inserts an all-zero bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e_pc  <= '0;
            r_e_ins <= '0;
            r_e_rs  <= '0;
            r_e_rt  <= '0;
            r_e_ext <= '0;
            r_e_a3  <= '0;
        end else if (E_Flush) begin
            r_e_pc  <= '0;
            r_e_ins <= '0;
            r_e_rs  <= '0;
            r_e_rt  <= '0;
            r_e_ext <= '0;
            r_e_a3  <= '0;
        end else begin
            r_e_pc  <= D_PC;
            r_e_ins <= D_Ins;
            r_e_rs  <= w_rs_v;
            r_e_rt  <= w_rt_v;
            r_e_ext <= w_ext;
            r_e_a3  <= w_a3;
        end
    end

    assign NPC   = w_npc;
    assign D_rs  = w_rs_a;
    assign D_rt  = w_rt_a;
    assign E_PC  = r_e_pc;
    assign E_Ins = r_e_ins;
    assign E_RS  = r_e_rs;
    assign E_RT  = r_e_rt;
    assign E_EXT = r_e_ext;
    assign E_A3  = r_e_a3;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: directed vectors push expectations,
// a monitor pops and compares after each rising edge.
module tb_decode;

    logic        clk;
    logic        reset;
    logic [31:0] D_PC, D_Ins, F_PC;
    logic        E_Flush;
    logic [4:0]  M_A3;
    logic [31:0] M_WD;
    logic        W_WE;
    logic [4:0]  W_A3;
    logic [31:0] W_WD;
    logic [31:0] NPC;
    logic [4:0]  D_rs, D_rt;
    logic [31:0] E_PC, E_Ins, E_RS, E_RT, E_EXT;
    logic [4:0]  E_A3;

    decode dut (
        .clk(clk), .reset(reset), .D_PC(D_PC), .D_Ins(D_Ins), .F_PC(F_PC),
        .E_Flush(E_Flush), .M_A3(M_A3), .M_WD(M_WD), .W_WE(W_WE),
        .W_A3(W_A3), .W_WD(W_WD), .NPC(NPC), .D_rs(D_rs), .D_rt(D_rt),
        .E_PC(E_PC), .E_Ins(E_Ins), .E_RS(E_RS), .E_RT(E_RT),
        .E_EXT(E_EXT), .E_A3(E_A3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] npc, pc, ins, rs, rt, ext;
        logic [4:0]  a3, drs, drt;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, expv);
        end
    endtask

    task automatic drv(input logic [31:0] ins, input logic [31:0] dpc,
                       input logic [31:0] fpc, input logic flush,
                       input logic [4:0] ma3, input logic [31:0] mwd,
                       input logic we, input logic [4:0] wa3, input logic [31:0] wwd);
        D_Ins = ins; D_PC = dpc; F_PC = fpc; E_Flush = flush;
        M_A3 = ma3; M_WD = mwd; W_WE = we; W_A3 = wa3; W_WD = wwd;
    endtask

    task automatic vec(input string nm, input logic [31:0] npc, input logic zero_e,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ext, input logic [4:0] a3);
        exp_t e;
        e.npc = npc;
        e.pc  = zero_e ? 32'h0 : D_PC;
        e.ins = zero_e ? 32'h0 : D_Ins;
        e.rs  = zero_e ? 32'h0 : rs;
        e.rt  = zero_e ? 32'h0 : rt;
        e.ext = zero_e ? 32'h0 : ext;
        e.a3  = zero_e ? 5'd0 : a3;
        e.drs = D_Ins[25:21];
        e.drt = D_Ins[20:16];
        q.push_back(e);
        nq.push_back(nm);
    endtask

    // Monitor: compare every pending expectation just after the rising edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n = nq.pop_front();
                chk(n, "NPC",   NPC,          e.npc);
                chk(n, "D_rs",  32'(D_rs),    32'(e.drs));
                chk(n, "D_rt",  32'(D_rt),    32'(e.drt));
                chk(n, "E_PC",  E_PC,         e.pc);
                chk(n, "E_Ins", E_Ins,        e.ins);
                chk(n, "E_RS",  E_RS,         e.rs);
                chk(n, "E_RT",  E_RT,         e.rt);
                chk(n, "E_EXT", E_EXT,        e.ext);
                chk(n, "E_A3",  32'(E_A3),    32'(e.a3));
            end
        end
    end

    localparam logic [31:0] PCD = 32'h0000_3004;
    localparam logic [31:0] PCF = 32'h0000_3008;
    localparam logic [31:0] SEQ = 32'h0000_300C;

    initial begin
        int waits;
        reset = 1'b0;
        drv(32'h0, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset held: E_* stay zero, NPC still combinational.
        @(negedge clk);
        drv(32'h0022_1821, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("rst_hold0", SEQ, 1'b1, 0, 0, 0, 0);
        @(negedge clk);
        vec("rst_hold1", SEQ, 1'b1, 0, 0, 0, 0);

        // Release: first edge loads; $1 via W bypass.
        @(negedge clk);
        reset = 1'b1;
        drv(32'h0022_1821, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h55);
        vec("release_bypass", SEQ, 1'b0, 32'h55, 0, 0, 5'd3);

        // Mid-operation reset: clears $1 and discards the $2 write.
        @(negedge clk);
        reset = 1'b0;
        drv(32'h0022_1821, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h77);
        vec("rst_mid", SEQ, 1'b1, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drv(32'h0022_1821, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("after_rst_addu", SEQ, 1'b0, 0, 0, 0, 5'd3);

        @(negedge clk);
        drv(32'h34A6_FFFF, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
        vec("ori_bypass", SEQ, 1'b0, 32'h1234, 0, 32'h0000_FFFF, 5'd6);
        @(negedge clk);
        drv(32'h3407_0000, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
        vec("w_to_zero", SEQ, 1'b0, 0, 0, 0, 5'd7);
        @(negedge clk);
        drv(32'h0005_4021, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("grf_read", SEQ, 1'b0, 0, 32'h1234, 0, 5'd8);

        @(negedge clk);
        drv(32'h00A0_4821, PCD, PCF, 1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
        vec("m_over_w", SEQ, 1'b0, 32'hAAAA, 0, 0, 5'd9);
        @(negedge clk);
        drv(32'h00A5_5021, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("grf_after_w", SEQ, 1'b0, 32'hBBBB, 32'hBBBB, 0, 5'd10);

        @(negedge clk);
        drv(32'h1022_FFFD, PCD, PCF, 1'b0, 5'd1, 32'h11, 1'b1, 5'd2, 32'h11);
        vec("beq_taken", 32'h0000_2FFC, 1'b0, 32'h11, 32'h11, 32'hFFFF_FFFD, 5'd0);
        @(negedge clk);
        drv(32'h1022_FFFD, PCD, PCF, 1'b0, 5'd1, 32'h22, 1'b0, 5'd0, 32'h0);
        vec("beq_not", SEQ, 1'b0, 32'h22, 32'h11, 32'hFFFF_FFFD, 5'd0);
        @(negedge clk);
        drv(32'h0C00_0C00, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("jal", 32'h0000_3000, 1'b0, 0, 0, 0, 5'd31);
        @(negedge clk);
        drv(32'h0080_0008, PCD, PCF, 1'b0, 5'd4, 32'h3040, 1'b0, 5'd0, 32'h0);
        vec("jr", 32'h0000_3040, 1'b0, 32'h3040, 0, 0, 5'd0);
        @(negedge clk);
        drv(32'h0800_0100, 32'hA000_0000, 32'hA000_0004, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("j_upper", 32'hA000_0400, 1'b0, 0, 0, 0, 5'd0);

        @(negedge clk);
        drv(32'h8C0B_8000, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("lw_sext", SEQ, 1'b0, 0, 0, 32'hFFFF_8000, 5'd11);
        @(negedge clk);
        drv(32'h3C0C_8000, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("lui", SEQ, 1'b0, 0, 0, 32'h8000_0000, 5'd12);
        @(negedge clk);
        drv(32'hAC0D_0004, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("sw", SEQ, 1'b0, 0, 0, 32'h4, 5'd0);
        @(negedge clk);
        drv(32'h00A0_7023, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("subu", SEQ, 1'b0, 32'hBBBB, 0, 0, 5'd14);
        @(negedge clk);
        drv(32'hFC00_0000, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("unknown_op", SEQ, 1'b0, 0, 0, 0, 5'd0);

        @(negedge clk);
        drv(32'h0022_1821, PCD, PCF, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("flush", SEQ, 1'b1, 0, 0, 0, 0);
        @(negedge clk);
        drv(32'h0022_1821, PCD, PCF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("after_flush", SEQ, 1'b0, 0, 32'h11, 0, 5'd3);
        @(negedge clk);
        drv(32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        vec("npc_wrap", 32'h0, 1'b0, 0, 0, 0, 5'd0);

        waits = 0;
        while (q.size() > 0 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
